// File: rtl/multicycle_pkg.sv
// Shared definitions for the multicycle controller: FSM state enum, instruction
// classes, RV32 opcode/funct3 constants, ALU operation codes, the decoder
// output payload and a funct3-to-ALU-op helper.
package multicycle_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned ALU_OP_W = 4;

    // Controller states
    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } state_t;

    // Instruction classes driving the sequencing
    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_ILLEGAL = 3'd4
    } iclass_t;

    // Opcodes
    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // funct3 values
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    // ALU operation codes
    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'b1000;
    localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'b1001;
    localparam logic [ALU_OP_W-1:0] ALU_SRA = 4'b1010;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'b1101;

    // Decoder result carried from the decode block to the sequencer
    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic                alu_src;
        iclass_t             iclass;
    } decode_t;

    // Shared funct3 map for R and I-ALU; SUB only exists in the R form,
    // while bit 30 selects the arithmetic right shift in both forms.
    function automatic logic [ALU_OP_W-1:0] f3_to_alu_op(
        input logic [2:0] f3,
        input logic       bit30,
        input logic       is_reg
    );
        logic [ALU_OP_W-1:0] op;
        op = ALU_ADD;
        case (f3)
            F3_ADD:  op = (is_reg && bit30) ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = bit30 ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            F3_AND:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/multicycle_decode.sv
// Combinational instruction decoder for the multicycle controller.
// Ports:
//   ir  - latched instruction register (only opcode, funct3 and bit 30 matter)
//   dec - ALU op, ALU operand select and instruction class
// funct3 = 011 (unsigned compare) has no ALU code, so it decodes as illegal.
module multicycle_decode
    import multicycle_pkg::*;
(
    input  logic [XLEN-1:0] ir,
    output decode_t         dec
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       bit30;
    logic       unused_ir_fields;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign bit30  = ir[30];

    // Register numbers and immediates belong to the datapath
    assign unused_ir_fields = ^{ir[31], ir[29:15], ir[11:7]};

    // Opcode/funct3 to control fields
    always_comb begin
        dec.alu_op  = ALU_ADD;
        dec.alu_src = 1'b0;
        dec.iclass  = CLS_ILLEGAL;
        case (opcode)
            OPC_R: begin
                if (funct3 != F3_SLTU) begin
                    dec.iclass = CLS_ALU;
                    dec.alu_op = f3_to_alu_op(funct3, bit30, 1'b1);
                end
            end
            OPC_I_ALU: begin
                if (funct3 != F3_SLTU) begin
                    dec.iclass  = CLS_ALU;
                    dec.alu_src = 1'b1;
                    dec.alu_op  = f3_to_alu_op(funct3, bit30, 1'b0);
                end
            end
            OPC_LOAD: begin
                if (funct3 == F3_WORD) begin
                    dec.iclass  = CLS_LOAD;
                    dec.alu_src = 1'b1;
                    dec.alu_op  = ALU_ADD;
                end
            end
            OPC_STORE: begin
                if (funct3 == F3_WORD) begin
                    dec.iclass  = CLS_STORE;
                    dec.alu_src = 1'b1;
                    dec.alu_op  = ALU_ADD;
                end
            end
            OPC_BRANCH: begin
                if (funct3 == F3_BEQ) begin
                    dec.iclass = CLS_BRANCH;
                    dec.alu_op = ALU_SUB;
                end
            end
            default: begin
                dec.iclass = CLS_ILLEGAL;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 subset control unit: IF/ID/EX/MEM/WB sequencer.
// Ports:
//   clk, rst (sync, active-low)      - clock and reset
//   instr                            - instruction word, captured into IR at end of IF
//   zero                             - ALU zero flag (branch resolution in EX)
//   dmem_ack                         - data-memory completion
//   alu_op, alu_src                  - ALU control, held from EX to the final cycle
//   mem_read, mem_write              - data-memory strobes during MEM
//   mem_to_reg, reg_write            - writeback select / enable in WB
//   load_pc, pc_src                  - PC update strobe and select
//   illegal                          - one-cycle pulse for an undecodable instruction
// Outputs are decoded from the state and IR registers; pc_src and the store
// completion strobe also follow zero/dmem_ack within the same cycle.
// Build option: define MULTICYCLE_CTRL_DMEM_HANDSHAKE_EN to stall in MEM until
// dmem_ack; otherwise MEM lasts exactly one cycle and dmem_ack is ignored.
module multicycle_ctrl
    import multicycle_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [XLEN-1:0]     instr,
    input  logic                zero,
    input  logic                dmem_ack,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                alu_src,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                load_pc,
    output logic                pc_src,
    output logic                illegal
);

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] ir;
    decode_t         dec;
    logic            mem_done;

    // Data-memory completion for the current MEM cycle
`ifdef MULTICYCLE_CTRL_DMEM_HANDSHAKE_EN
    assign mem_done = dmem_ack;
`else
    logic unused_dmem_ack;
    assign mem_done        = 1'b1;
    assign unused_dmem_ack = dmem_ack;
`endif

    multicycle_decode u_decode (
        .ir  (ir),
        .dec (dec)
    );

    // State and instruction register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IF;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IF) begin
                ir <= instr;
            end
        end
    end

    // Next-state sequencing
    always_comb begin
        state_nxt = ST_IF;
        case (state)
            ST_IF: state_nxt = ST_ID;
            ST_ID: state_nxt = (dec.iclass == CLS_ILLEGAL) ? ST_IF : ST_EX;
            ST_EX: begin
                case (dec.iclass)
                    CLS_ALU:   state_nxt = ST_WB;
                    CLS_LOAD,
                    CLS_STORE: state_nxt = ST_MEM;
                    default:   state_nxt = ST_IF;
                endcase
            end
            ST_MEM: begin
                if (!mem_done) begin
                    state_nxt = ST_MEM;
                end else if (dec.iclass == CLS_LOAD) begin
                    state_nxt = ST_WB;
                end else begin
                    state_nxt = ST_IF;
                end
            end
            ST_WB:   state_nxt = ST_IF;
            default: state_nxt = ST_IF;
        endcase
    end

    // Control outputs per state
    always_comb begin
        alu_op     = '0;
        alu_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        load_pc    = 1'b0;
        pc_src     = 1'b0;
        illegal    = 1'b0;
        case (state)
            ST_ID: begin
                if (dec.iclass == CLS_ILLEGAL) begin
                    illegal = 1'b1;
                    load_pc = 1'b1;
                end
            end
            ST_EX: begin
                alu_op  = dec.alu_op;
                alu_src = dec.alu_src;
                if (dec.iclass == CLS_BRANCH) begin
                    load_pc = 1'b1;
                    pc_src  = zero;
                end
            end
            ST_MEM: begin
                alu_op  = dec.alu_op;
                alu_src = dec.alu_src;
                if (dec.iclass == CLS_LOAD) begin
                    mem_read = 1'b1;
                end else begin
                    mem_write = 1'b1;
                    load_pc   = mem_done;
                end
            end
            ST_WB: begin
                alu_op     = dec.alu_op;
                alu_src    = dec.alu_src;
                reg_write  = 1'b1;
                load_pc    = 1'b1;
                mem_to_reg = (dec.iclass == CLS_LOAD);
            end
            default: begin
                alu_op = '0;
            end
        endcase
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port instr, input, 32 bits: instruction word from instruction memory, valid during IF.
REQ-004 SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-005 SHALL have port dmem_ack, input, 1 bit: data-memory access complete.
REQ-006 SHALL have port alu_op, output, 4 bits: ALU operation code.
REQ-007 SHALL have port alu_src, output, 1 bit: 0 selects register op2, 1 selects immediate.
REQ-008 SHALL have ports mem_read and mem_write, outputs, 1 bit each: data-memory strobes.
REQ-009 SHALL have ports mem_to_reg and reg_write, outputs, 1 bit each: writeback select (1 = memory data) and register-file write enable.
REQ-010 SHALL have ports load_pc and pc_src, outputs, 1 bit each: PC update strobe and select (0 = PC+4, 1 = branch target).
REQ-011 SHALL have port illegal, output, 1 bit: one-cycle pulse for an undecodable instruction.

Function
REQ-012 SHALL implement states IF, ID, EX, MEM, WB; IF->ID always; instr latched into an internal IR at end of IF.
REQ-013 SHALL decode from IR only: R 0110011, I-ALU 0010011, LW 0000011 (f3 010), SW 0100011 (f3 010), BEQ 1100011 (f3 000); anything else is illegal.
REQ-014 SHALL map to alu_op: ADD 0010, SUB 0110, AND 0000, OR 0001, XOR 1101, SLT 0111, SLL 1001, SRL 1000, SRA 1010; I-ALU uses the same map (no SUB; SRAI selected by IR[30]); LW/SW use ADD; BEQ uses SUB.
REQ-015 SHALL take transitions ID->EX (legal) or ID->IF (illegal); EX->WB (R, I-ALU), EX->MEM (LW, SW), EX->IF (BEQ); MEM->WB (LW) or MEM->IF (SW) on completion; WB->IF.
REQ-016 SHALL drive alu_op and alu_src constant from EX through the instruction's final cycle; alu_src = 1 for I-ALU, LW, SW.
REQ-017 SHALL assert mem_read (LW) or mem_write (SW) throughout MEM only.
REQ-018 SHALL assert reg_write for exactly one cycle in WB, with mem_to_reg = 1 for LW only.
REQ-019 SHALL assert load_pc for exactly one cycle in each instruction's final state: WB (R, I-ALU, LW), MEM completion cycle (SW), EX (BEQ), ID (illegal).
REQ-020 SHALL drive pc_src = zero during BEQ EX; pc_src = 0 at all other times.
REQ-021 SHALL give latencies IF-to-IF: R/I-ALU 4, BEQ 3, SW 4 + waits, LW 5 + waits, illegal 2.
REQ-022 SHALL deassert illegal, reg_write, mem_read, mem_write and load_pc outside the cycles defined above.

Reset
REQ-023 SHALL, while rst = 0 at a rising edge, enter IF, clear IR, and drive every output to 0 from that edge.
REQ-024 SHALL abort any in-flight instruction on reset, including during MEM waits, with no further strobes for it.

Configuration
REQ-025 SHALL, with MULTICYCLE_CTRL_DMEM_HANDSHAKE_EN defined, remain in MEM until dmem_ack = 1 (completion cycle = first cycle dmem_ack is sampled high).
REQ-026 SHALL, without MULTICYCLE_CTRL_DMEM_HANDSHAKE_EN, hold MEM for exactly one cycle and ignore dmem_ack.

Structure
REQ-027 SHALL place the ALU op codes, opcode/funct constants and the state enum in shared package multicycle_pkg.
REQ-028 SHALL implement decoding (IR to alu_op, alu_src and instruction class) in combinational sub-module multicycle_decode.

Verification
REQ-029 SHALL cover ADD x3,x1,x2 (0x002081B3): alu_op 0010 from cycle 3, reg_write and load_pc in cycle 4; SUB (0x402081B3) gives 0110.
REQ-030 SHALL cover BEQ 0x00208463: zero = 1 gives load_pc = 1 and pc_src = 1 in cycle 3; zero = 0 gives pc_src = 0.
REQ-031 SHALL cover LW 0x0000A183 with HANDSHAKE_EN and dmem_ack high on the 3rd MEM cycle: mem_read held 3 cycles, then reg_write and mem_to_reg in WB.
REQ-032 SHALL cover SRAI 0x4040D193: alu_op 1010 and alu_src 1; instr 0xFFFFFFFF gives illegal and load_pc pulses in ID, with no reg_write.
REQ-033 SHALL cover rst = 0 during SW MEM wait: all outputs 0 next edge, and the FSM restarts in IF with mem_write never reasserted.
